uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one uart_tx instance between NREQ byte-stream requesters. It grants the UART to one requester for a whole frame, ending on the requester's last-flagged byte. It then fetches each byte over valid/ready, issues tx_start/din to uart_tx, and waits for tx_done_tick before fetching the next byte. A frame stalled by its requester is aborted after a configurable timeout.

---
 rtl/uart_tx_arbiter.sv | 139 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx between NREQ byte-stream requesters.
// A grant lasts a whole frame; a frame stalled by its requester is dropped after TIMEOUT cycles.
module uart_tx_arbiter #(
   parameter int  NREQ    = 4,
   parameter int  DBIT    = 8,
   parameter int  TIMEOUT = 1024,
   localparam int IW      = $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*DBIT-1:0] req_data,
   input  logic [NREQ-1:0]      req_last,
   output logic [NREQ-1:0]      req_ready,
   output logic                 tx_start,
   output logic [DBIT-1:0]      tx_din,
   input  logic                 tx_done_tick,
   output logic [IW-1:0]        grant_id,
   output logic                 busy,
   output logic                 frame_done,
   output logic                 frame_abort
);

   localparam int            CW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CntMax = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

   typedef enum logic [1:0] {StIdle, StFetch, StSend, StWait} state_e;

   state_e          state;
   logic [IW-1:0]   rr_ptr;
   logic [CW-1:0]   cnt;
   logic            last_reg;

   logic            pick_any;
   logic [IW-1:0]   pick_idx;
   logic [IW-1:0]   grant_nxt;
   logic            sel_valid;
   logic            sel_last;
   logic [DBIT-1:0] sel_data;
   int              best_off;
   int              off;

   // Lowest rotational distance from rr_ptr wins.
   always_comb begin
      pick_any = 1'b0;
      pick_idx = '0;
      best_off = NREQ;
      off      = 0;
      for (int i = 0; i < NREQ; i++) begin
         off = (i >= int'(rr_ptr)) ? i - int'(rr_ptr) : i + NREQ - int'(rr_ptr);
         if (req_valid[i] && (off < best_off)) begin
            best_off = off;
            pick_any = 1'b1;
            pick_idx = IW'(i);
         end
      end
   end

   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_id == IW'(i)) begin
            sel_valid = req_valid[i];
            sel_last  = req_last[i];
            sel_data  = req_data[i*DBIT +: DBIT];
         end
      end
   end

   always_comb begin
      req_ready = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_ready[i] = (state == StFetch) && (grant_id == IW'(i));
      end
   end

   assign grant_nxt = (int'(grant_id) == NREQ - 1) ? '0 : grant_id + 1'b1;
   assign busy      = (state != StIdle);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= StIdle;
         rr_ptr      <= '0;
         grant_id    <= '0;
         tx_din      <= '0;
         tx_start    <= 1'b0;
         frame_done  <= 1'b0;
         frame_abort <= 1'b0;
         cnt         <= '0;
         last_reg    <= 1'b0;
      end else begin
         tx_start    <= 1'b0;
         frame_done  <= 1'b0;
         frame_abort <= 1'b0;
         unique case (state)
            StIdle: begin
               if (pick_any) begin
                  grant_id <= pick_idx;
                  cnt      <= '0;
                  state    <= StFetch;
               end
            end
            StFetch: begin
               if (sel_valid) begin
                  tx_din   <= sel_data;
                  last_reg <= sel_last;
                  cnt      <= '0;
                  tx_start <= 1'b1;
                  state    <= StSend;
               end else if ((TIMEOUT > 0) && (cnt == CntMax)) begin
                  frame_abort <= 1'b1;
                  rr_ptr      <= grant_nxt;
                  cnt         <= '0;
                  state       <= StIdle;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            StSend: state <= StWait;
            StWait: begin
               // A done tick seen in any other state belongs to a byte we no longer own.
               if (tx_done_tick) begin
                  if (last_reg) begin
                     frame_done <= 1'b1;
                     rr_ptr     <= grant_nxt;
                     state      <= StIdle;
                  end else begin
                     state <= StFetch;
                  end
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester queue models, uart_tx done-tick stubs,
// and one DUT per timeout setting (1024 for normal traffic, 16 for abort).
module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        reset;

   logic [3:0]  a_valid, a_last, a_ready;
   logic [31:0] a_data;
   logic        a_start, a_done, a_busy, a_fdone, a_fabort;
   logic [7:0]  a_din;
   logic [1:0]  a_gid;

   logic [3:0]  b_valid, b_last, b_ready;
   logic [31:0] b_data;
   logic        b_start, b_done, b_busy, b_fdone, b_fabort;
   logic [7:0]  b_din;
   logic [1:0]  b_gid;

   logic stub_en     = 1'b1;
   logic stub_done_a = 1'b0;
   logic stray_a     = 1'b0;
   logic stub_done_b = 1'b0;

   logic [7:0] src_mem   [4][16];
   logic       src_lastf [4][16];
   int         src_total [4] = '{0, 0, 0, 0};
   int         src_sent  [4] = '{0, 0, 0, 0};
   logic [3:0] take;

   int         cyc = 0;
   logic [1:0] st_gid [$];
   logic [7:0] st_din [$];
   int         st_cyc [$];
   int         dn_cyc [$];

   int n_tests = 0;
   int n_fail  = 0;

   uart_tx_arbiter #(.NREQ(4), .DBIT(8), .TIMEOUT(1024)) dut_a (
      .clk(clk), .reset(reset), .req_valid(a_valid), .req_data(a_data), .req_last(a_last),
      .req_ready(a_ready), .tx_start(a_start), .tx_din(a_din), .tx_done_tick(a_done),
      .grant_id(a_gid), .busy(a_busy), .frame_done(a_fdone), .frame_abort(a_fabort)
   );

   uart_tx_arbiter #(.NREQ(4), .DBIT(8), .TIMEOUT(16)) dut_b (
      .clk(clk), .reset(reset), .req_valid(b_valid), .req_data(b_data), .req_last(b_last),
      .req_ready(b_ready), .tx_start(b_start), .tx_din(b_din), .tx_done_tick(b_done),
      .grant_id(b_gid), .busy(b_busy), .frame_done(b_fdone), .frame_abort(b_fabort)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign a_done = stub_done_a | stray_a;
   assign b_done = stub_done_b;

   // Requester queues: valid while bytes remain, advance one byte per accepted handshake.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         a_valid[i]       = src_sent[i] < src_total[i];
         a_data[i*8 +: 8] = src_mem[i][src_sent[i] % 16];
         a_last[i]        = src_lastf[i][src_sent[i] % 16];
      end
   end

   always begin
      @(negedge clk);
      take = a_valid & a_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) if (take[i]) src_sent[i] = src_sent[i] + 1;
   end

   // uart_tx stand-ins: done tick three cycles after each start.
   always begin
      @(negedge clk);
      if (a_start) begin
         repeat (3) @(posedge clk);
         #1 stub_done_a = stub_en;
         @(posedge clk);
         #1 stub_done_a = 1'b0;
      end
   end

   always begin
      @(negedge clk);
      if (b_start) begin
         repeat (3) @(posedge clk);
         #1 stub_done_b = 1'b1;
         @(posedge clk);
         #1 stub_done_b = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (a_start) begin
         st_gid.push_back(a_gid);
         st_din.push_back(a_din);
         st_cyc.push_back(cyc);
      end
      if (a_done) dn_cyc.push_back(cyc);
   end

   task automatic load_byte(input int r, input logic [7:0] d, input logic l);
      src_mem[r][src_total[r] % 16]   = d;
      src_lastf[r][src_total[r] % 16] = l;
      src_total[r] = src_total[r] + 1;
   endtask

   task automatic apply_reset();
      @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_tests++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", a_busy); end
      n_tests++; if (a_ready !== 4'h0) begin n_fail++; $display("FAIL rst_ready: got %h want 0", a_ready); end
      n_tests++; if (a_start !== 1'b0) begin n_fail++; $display("FAIL rst_start: got %b want 0", a_start); end
      n_tests++; if (a_gid !== 2'd0) begin n_fail++; $display("FAIL rst_gid: got %0d want 0", a_gid); end
      n_tests++; if (a_din !== 8'h00) begin n_fail++; $display("FAIL rst_din: got %h want 00", a_din); end
      n_tests++; if ({a_fdone, a_fabort} !== 2'b00) begin
         n_fail++; $display("FAIL rst_pulses: got %b want 00", {a_fdone, a_fabort});
      end
      @(posedge clk);
      #1 reset = 1'b1;
      repeat (3) @(negedge clk);
      n_tests++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", a_busy); end
   endtask

   task automatic test_single();
      int s0, d0, fd_c;
      logic seen;
      logic [7:0] exp [3] = '{8'h55, 8'hA3, 8'h0F};
      s0 = st_din.size();
      d0 = dn_cyc.size();
      @(posedge clk);
      #1;
      load_byte(0, 8'h55, 1'b0);
      load_byte(0, 8'hA3, 1'b0);
      load_byte(0, 8'h0F, 1'b1);
      seen = 1'b0;
      for (int t = 0; t < 200 && !seen; t++) begin @(negedge clk); seen = a_fdone; end
      fd_c = cyc;
      n_tests++; if (!seen) begin n_fail++; $display("FAIL single_done: got 0 want 1"); end
      n_tests++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b want 0", a_busy); end
      n_tests++; if (a_gid !== 2'd0) begin n_fail++; $display("FAIL single_gid: got %0d want 0", a_gid); end
      repeat (2) @(negedge clk);
      n_tests++; if (a_fdone !== 1'b0) begin n_fail++; $display("FAIL single_pulse: got %b want 0", a_fdone); end
      n_tests++; if (st_din.size() - s0 != 3) begin
         n_fail++; $display("FAIL single_nstart: got %0d want 3", st_din.size() - s0);
      end
      for (int j = 0; j < 3; j++) begin
         n_tests++; if (st_din[s0+j] !== exp[j] || st_gid[s0+j] !== 2'd0) begin
            n_fail++; $display("FAIL single_byte%0d: got %h/g%0d want %h/g0", j, st_din[s0+j], st_gid[s0+j], exp[j]);
         end
      end
      n_tests++; if (fd_c != dn_cyc[d0+2] + 1) begin
         n_fail++; $display("FAIL single_done_lat: got cycle %0d want %0d", fd_c, dn_cyc[d0+2] + 1);
      end
   endtask

   task automatic test_pair();
      int s0, d0, got, gap;
      apply_reset();
      s0 = st_din.size();
      d0 = dn_cyc.size();
      @(posedge clk);
      #1;
      load_byte(1, 8'h11, 1'b1);
      load_byte(2, 8'h22, 1'b1);
      got = 0;
      for (int t = 0; t < 300 && got < 2; t++) begin @(negedge clk); if (a_fdone) got++; end
      n_tests++; if (got != 2) begin n_fail++; $display("FAIL pair_frames: got %0d want 2", got); end
      repeat (2) @(negedge clk);
      n_tests++; if (st_gid[s0] !== 2'd1 || st_din[s0] !== 8'h11) begin
         n_fail++; $display("FAIL pair_first: got g%0d/%h want g1/11", st_gid[s0], st_din[s0]);
      end
      n_tests++; if (st_gid[s0+1] !== 2'd2 || st_din[s0+1] !== 8'h22) begin
         n_fail++; $display("FAIL pair_second: got g%0d/%h want g2/22", st_gid[s0+1], st_din[s0+1]);
      end
      gap = st_cyc[s0+1] - dn_cyc[d0];
      n_tests++; if (gap < 2) begin n_fail++; $display("FAIL pair_gap: got %0d want >=2", gap); end
      // rr_ptr now 3: requester 3 outranks 0, then the pointer wraps to 0.
      s0 = st_din.size();
      @(posedge clk);
      #1;
      load_byte(0, 8'h0A, 1'b1);
      load_byte(3, 8'h3A, 1'b1);
      got = 0;
      for (int t = 0; t < 300 && got < 2; t++) begin @(negedge clk); if (a_fdone) got++; end
      repeat (2) @(negedge clk);
      n_tests++; if (st_gid[s0] !== 2'd3 || st_gid[s0+1] !== 2'd0) begin
         n_fail++; $display("FAIL pair_wrap: got g%0d,g%0d want g3,g0", st_gid[s0], st_gid[s0+1]);
      end
   endtask

   task automatic test_round_robin();
      int s0, got;
      apply_reset();
      s0 = st_din.size();
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++)
         for (int r = 0; r < 4; r++) load_byte(r, 8'(r * 16 + k), 1'b1);
      got = 0;
      for (int t = 0; t < 1000 && got < 12; t++) begin @(negedge clk); if (a_fdone) got++; end
      n_tests++; if (got != 12) begin n_fail++; $display("FAIL rr_frames: got %0d want 12", got); end
      repeat (2) @(negedge clk);
      for (int j = 0; j < 12; j++) begin
         n_tests++; if (st_gid[s0+j] !== 2'(j % 4) || st_din[s0+j] !== 8'((j % 4) * 16 + j / 4)) begin
            n_fail++; $display("FAIL rr_order%0d: got g%0d/%h want g%0d/%h", j, st_gid[s0+j], st_din[s0+j],
                               j % 4, 8'((j % 4) * 16 + j / 4));
         end
      end
   endtask

   task automatic test_gap();
      int s0, starts, fa;
      logic seen;
      logic [7:0] exp [3] = '{8'h31, 8'h32, 8'h33};
      apply_reset();
      s0 = st_din.size();
      @(posedge clk);
      #1 load_byte(3, 8'h31, 1'b0);
      seen = 1'b0;
      for (int t = 0; t < 20 && !seen; t++) begin @(negedge clk); seen = a_start; end
      n_tests++; if (!seen) begin n_fail++; $display("FAIL gap_first_start: got 0 want 1"); end
      @(posedge clk);
      #1 load_byte(1, 8'h99, 1'b1);
      starts = 0;
      fa = 0;
      repeat (50) begin
         @(negedge clk);
         if (a_start) starts++;
         if (a_fabort) fa++;
      end
      n_tests++; if (starts != 0) begin n_fail++; $display("FAIL gap_starts: got %0d want 0", starts); end
      n_tests++; if (a_ready !== 4'b1000 || a_gid !== 2'd3) begin
         n_fail++; $display("FAIL gap_hold: got ready %b g%0d want 1000 g3", a_ready, a_gid);
      end
      @(posedge clk);
      #1;
      load_byte(3, 8'h32, 1'b0);
      load_byte(3, 8'h33, 1'b1);
      seen = 1'b0;
      for (int t = 0; t < 100 && !seen; t++) begin
         @(negedge clk);
         seen = a_fdone;
         if (a_fabort) fa++;
      end
      n_tests++; if (!seen || fa != 0) begin
         n_fail++; $display("FAIL gap_resume: got done %b aborts %0d want 1/0", seen, fa);
      end
      seen = 1'b0;
      for (int t = 0; t < 20 && !seen; t++) begin @(negedge clk); seen = a_start; end
      n_tests++; if (!seen || a_gid !== 2'd1 || a_din !== 8'h99) begin
         n_fail++; $display("FAIL gap_next: got g%0d/%h want g1/99", a_gid, a_din);
      end
      seen = 1'b0;
      for (int t = 0; t < 20 && !seen; t++) begin @(negedge clk); seen = a_fdone; end
      for (int j = 0; j < 3; j++) begin
         n_tests++; if (st_din[s0+j] !== exp[j] || st_gid[s0+j] !== 2'd3) begin
            n_fail++; $display("FAIL gap_byte%0d: got %h/g%0d want %h/g3", j, st_din[s0+j], st_gid[s0+j], exp[j]);
         end
      end
   endtask

   task automatic test_timeout();
      int f_cyc, a_cyc, starts;
      logic seen;
      apply_reset();
      @(posedge clk);
      #1;
      b_data  = 32'h0000_C1B0;
      b_last  = 4'b0010;
      b_valid = 4'b0011;
      seen = 1'b0;
      for (int t = 0; t < 20 && !seen; t++) begin @(negedge clk); seen = b_ready[0]; end
      n_tests++; if (!seen) begin n_fail++; $display("FAIL to_grant0: got 0 want 1"); end
      @(posedge clk);
      #1 b_valid[0] = 1'b0;
      seen = 1'b0;
      for (int t = 0; t < 20 && !seen; t++) begin @(negedge clk); seen = b_start; end
      seen = 1'b0;
      for (int t = 0; t < 20 && !seen; t++) begin @(negedge clk); seen = b_ready[0]; end
      f_cyc = cyc;
      seen = 1'b0;
      starts = 0;
      for (int t = 0; t < 40 && !seen; t++) begin
         @(negedge clk);
         seen = b_fabort;
         if (b_start) starts++;
      end
      a_cyc = cyc;
      n_tests++; if (!seen || a_cyc - f_cyc != 16) begin
         n_fail++; $display("FAIL to_latency: got %0d cycles (seen %b) want 16", a_cyc - f_cyc, seen);
      end
      n_tests++; if (starts != 0) begin n_fail++; $display("FAIL to_starts: got %0d want 0", starts); end
      n_tests++; if (b_busy !== 1'b0 || b_fdone !== 1'b0) begin
         n_fail++; $display("FAIL to_idle: got busy %b done %b want 0/0", b_busy, b_fdone);
      end
      seen = 1'b0;
      for (int t = 0; t < 10 && !seen; t++) begin @(negedge clk); seen = b_ready[1]; end
      n_tests++; if (!seen || b_gid !== 2'd1) begin
         n_fail++; $display("FAIL to_next_grant: got g%0d (seen %b) want g1", b_gid, seen);
      end
      @(posedge clk);
      #1 b_valid[1] = 1'b0;
      seen = 1'b0;
      for (int t = 0; t < 20 && !seen; t++) begin @(negedge clk); seen = b_start; end
      n_tests++; if (!seen || b_din !== 8'hC1) begin
         n_fail++; $display("FAIL to_next_byte: got %h want c1", b_din);
      end
      seen = 1'b0;
      for (int t = 0; t < 20 && !seen; t++) begin @(negedge clk); seen = b_fdone; end
      n_tests++; if (!seen) begin n_fail++; $display("FAIL to_next_done: got 0 want 1"); end
      b_data = '0;
      b_last = '0;
   endtask

   task automatic test_reset_mid();
      int starts, fd, fa, bz;
      apply_reset();
      @(posedge clk);
      #1;
      load_byte(2, 8'h41, 1'b0);
      load_byte(2, 8'h42, 1'b0);
      load_byte(2, 8'h43, 1'b1);
      starts = 0;
      for (int t = 0; t < 100 && starts < 2; t++) begin @(negedge clk); if (a_start) starts++; end
      n_tests++; if (starts != 2) begin n_fail++; $display("FAIL rm_setup: got %0d starts want 2", starts); end
      stub_en = 1'b0;
      @(posedge clk);
      #1;
      src_total[2] = src_sent[2];
      reset = 1'b0;
      #1;
      n_tests++; if (a_busy !== 1'b0 || a_ready !== 4'h0 || a_start !== 1'b0) begin
         n_fail++; $display("FAIL rm_ctrl: got busy %b ready %h start %b want 0/0/0", a_busy, a_ready, a_start);
      end
      n_tests++; if (a_gid !== 2'd0 || a_din !== 8'h00) begin
         n_fail++; $display("FAIL rm_regs: got g%0d din %h want g0/00", a_gid, a_din);
      end
      fa = 0;
      @(negedge clk);
      if (a_fabort) fa++;
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 stray_a = 1'b1;
      @(posedge clk);
      #1 stray_a = 1'b0;
      starts = 0;
      fd = 0;
      bz = 0;
      repeat (10) begin
         @(negedge clk);
         if (a_start) starts++;
         if (a_fdone) fd++;
         if (a_fabort) fa++;
         if (a_busy) bz++;
      end
      n_tests++; if (starts != 0 || fd != 0 || fa != 0) begin
         n_fail++; $display("FAIL rm_stray: got starts %0d done %0d abort %0d want 0/0/0", starts, fd, fa);
      end
      n_tests++; if (bz != 0 || a_din !== 8'h00 || a_gid !== 2'd0) begin
         n_fail++; $display("FAIL rm_after: got busy %0d din %h g%0d want 0/00/g0", bz, a_din, a_gid);
      end
      stub_en = 1'b1;
   endtask

   initial begin
      reset   = 1'b0;
      b_valid = '0;
      b_data  = '0;
      b_last  = '0;
      repeat (2) @(posedge clk);
      test_reset();
      test_single();
      test_pair();
      test_round_robin();
      test_gap();
      test_timeout();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
